// File: rtl/f2_motion_ctrl_if.sv
// Command/status bundle between the key-processing stage and the cursor controller.
// Latency: n/a (signal bundle only).
// Backpressure: none; instruction is a level code, status outputs are registered.
interface f2_motion_ctrl_if #(
  parameter int COORD_W = 4
);
  logic [2:0]         instruction;
  logic [COORD_W-1:0] pos_x;
  logic [COORD_W-1:0] pos_y;
  logic [1:0]         heading;
  logic               busy;
  logic               bump;
  logic               nav_done;

  modport master (
    output instruction,
    input  pos_x, pos_y, heading, busy, bump, nav_done
  );

  modport slave (
    input  instruction,
    output pos_x, pos_y, heading, busy, bump, nav_done
  );
endinterface

// File: rtl/f2_motion_ctrl.sv
// Cursor position/heading controller on a cell grid; one action per key press, navigate-home walker.
// Latency: a press sampled at a sysclk edge updates outputs on that same edge; navigate steps every STEP_DIV cycles.
// Backpressure: none; presses arriving while navigating abort (1/2/3) or are ignored (4).
module f2_motion_ctrl #(
  parameter int GRID_W   = 16,
  parameter int GRID_H   = 12,
  parameter int COORD_W  = 4,
  parameter int HOME_X   = 0,
  parameter int HOME_Y   = 0,
  parameter int STEP_DIV = 25000000
) (
  input  logic              sysclk,
  input  logic              rst_n,
  f2_motion_ctrl_if.slave   bus
);

  localparam int                 CNT_W    = $clog2(STEP_DIV);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(STEP_DIV - 1);
  localparam logic [COORD_W-1:0] HX       = COORD_W'(HOME_X);
  localparam logic [COORD_W-1:0] HY       = COORD_W'(HOME_Y);
  localparam logic [COORD_W-1:0] XMAX     = COORD_W'(GRID_W - 1);
  localparam logic [COORD_W-1:0] YMAX     = COORD_W'(GRID_H - 1);

  typedef enum logic {IDLE, NAV} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         prev_q;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [1:0]         hd_q, hd_d;
  logic               bump_q, bump_d, done_q, done_d;
  logic [2:0]         cmd;
  logic               press;
  logic [1:0]         mv_dir;

  // Next-state logic: decode, press-edge detect, single-cell moves and navigate stepping.
  always_comb begin
    cmd     = (bus.instruction > 3'd4) ? 3'd0 : bus.instruction;
    press   = (cmd != 3'd0) && (prev_q == 3'd0);
    // Backward travels opposite the current heading without changing it.
    mv_dir  = (cmd == 3'd2) ? (hd_q + 2'd2) : hd_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    hd_d    = hd_q;
    bump_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (press) begin
          case (cmd)
            3'd1, 3'd2: begin
              case (mv_dir)
                2'd0: if (y_q == '0)   bump_d = 1'b1; else y_d = y_q - 1'b1;
                2'd1: if (x_q == XMAX) bump_d = 1'b1; else x_d = x_q + 1'b1;
                2'd2: if (y_q == YMAX) bump_d = 1'b1; else y_d = y_q + 1'b1;
                default: if (x_q == '0) bump_d = 1'b1; else x_d = x_q - 1'b1;
              endcase
            end
            3'd3: hd_d = hd_q + 2'd1;
            3'd4: begin
              if (x_q == HX && y_q == HY) begin
                done_d = 1'b1;
              end else begin
                state_d = NAV;
                cnt_d   = '0;
              end
            end
            default: ;
          endcase
        end
      end
      default: begin
        // Abort has priority over a step landing on the same edge.
        if (press && cmd != 3'd4) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          // Close the x gap first, then y; heading follows the direction of travel.
          if (x_q != HX) begin
            if (x_q > HX) begin x_d = x_q - 1'b1; hd_d = 2'd3; end
            else          begin x_d = x_q + 1'b1; hd_d = 2'd1; end
          end else begin
            if (y_q > HY) begin y_d = y_q - 1'b1; hd_d = 2'd0; end
            else          begin y_d = y_q + 1'b1; hd_d = 2'd2; end
          end
          if (x_d == HX && y_d == HY) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  // State register with synchronous active-low reset; prev_q tracks the decoded code every cycle.
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prev_q  <= 3'd0;
      x_q     <= HX;
      y_q     <= HY;
      hd_q    <= 2'd0;
      bump_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prev_q  <= cmd;
      x_q     <= x_d;
      y_q     <= y_d;
      hd_q    <= hd_d;
      bump_q  <= bump_d;
      done_q  <= done_d;
    end
  end

  assign bus.pos_x    = x_q;
  assign bus.pos_y    = y_q;
  assign bus.heading  = hd_q;
  assign bus.busy     = (state_q == NAV);
  assign bus.bump     = bump_q;
  assign bus.nav_done = done_q;

endmodule

// File: tb/tb_f2_motion_ctrl.sv
// Self-checking bench for f2_motion_ctrl: directed scenarios plus randomized key streams vs a reference model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_f2_motion_ctrl;
  localparam int GW = 16, GH = 12, CW = 4, HX = 0, HY = 0, SD = 4;

  logic sysclk = 1'b0;
  logic rst_n  = 1'b0;
  int   checks = 0;
  int   errors = 0;

  f2_motion_ctrl_if #(.COORD_W(CW)) bus ();

  f2_motion_ctrl #(
    .GRID_W(GW), .GRID_H(GH), .COORD_W(CW), .HOME_X(HX), .HOME_Y(HY), .STEP_DIV(SD)
  ) dut (
    .sysclk(sysclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 sysclk = ~sysclk;

  // Reference model: cursor in plain integers, navigate timed by cycles since entry.
  int m_x = HX, m_y = HY, m_h = 0, m_prev = 0, m_t = 0;
  bit m_busy = 0, m_bump = 0, m_done = 0;
  int DX[4] = '{0, 1, 0, -1};
  int DY[4] = '{-1, 0, 1, 0};

  task automatic model_step(input logic [2:0] code, input logic rn);
    int c, d, nx, ny;
    bit pe;
    c  = (code > 3'd4) ? 0 : int'(code);
    pe = (c != 0) && (m_prev == 0);
    m_bump = 0;
    m_done = 0;
    if (!rn) begin
      m_x = HX; m_y = HY; m_h = 0; m_busy = 0; m_t = 0; m_prev = 0;
      return;
    end
    m_prev = c;
    if (!m_busy) begin
      if (pe) begin
        if (c == 1 || c == 2) begin
          d  = (c == 2) ? (m_h + 2) % 4 : m_h;
          nx = m_x + DX[d];
          ny = m_y + DY[d];
          if (nx < 0 || nx >= GW || ny < 0 || ny >= GH) m_bump = 1;
          else begin m_x = nx; m_y = ny; end
        end else if (c == 3) begin
          m_h = (m_h + 1) % 4;
        end else if (c == 4) begin
          if (m_x == HX && m_y == HY) m_done = 1;
          else begin m_busy = 1; m_t = 0; end
        end
      end
    end else if (pe && c != 4) begin
      m_busy = 0;
    end else begin
      m_t++;
      if (m_t == SD) begin
        m_t = 0;
        if (m_x != HX) begin
          m_h = (m_x > HX) ? 3 : 1;
          m_x += (m_x > HX) ? -1 : 1;
        end else begin
          m_h = (m_y > HY) ? 0 : 2;
          m_y += (m_y > HY) ? -1 : 1;
        end
        if (m_x == HX && m_y == HY) begin m_done = 1; m_busy = 0; end
      end
    end
  endtask

  task automatic tick(input logic [2:0] code, input logic rn);
    bus.instruction = code;
    rst_n           = rn;
    @(posedge sysclk);
    model_step(code, rn);
    #1;
  endtask

  task automatic press(input logic [2:0] code);
    tick(code, 1'b1);
    tick(3'd0, 1'b1);
  endtask

  // Reset then walk to (3,5) facing S.
  task automatic goto_35();
    tick(3'd0, 1'b0);
    tick(3'd0, 1'b0);
    tick(3'd0, 1'b1);
    press(3'd3);
    for (int i = 0; i < 3; i++) press(3'd1);
    press(3'd3);
    for (int i = 0; i < 5; i++) press(3'd1);
  endtask

  task automatic test_reset();
    tick(3'd0, 1'b0);
    tick(3'd0, 1'b0);
    checks++;
    if ({bus.pos_x, bus.pos_y, bus.heading, bus.busy, bus.bump, bus.nav_done} !== 13'd0) begin
      errors++;
      $display("FAIL reset got x=%0d y=%0d h=%0d busy=%0b bump=%0b done=%0b want all 0",
               bus.pos_x, bus.pos_y, bus.heading, bus.busy, bus.bump, bus.nav_done);
    end
  endtask

  task automatic test_border_hold();
    for (int i = 0; i < 10; i++) begin
      tick(3'd1, 1'b1);
      checks++;
      if (bus.bump !== (i == 0) || bus.pos_x !== 4'd0 || bus.pos_y !== 4'd0) begin
        errors++;
        $display("FAIL border_hold cyc%0d got bump=%0b pos=(%0d,%0d) want bump=%0b pos=(0,0)",
                 i, bus.bump, bus.pos_x, bus.pos_y, (i == 0));
      end
    end
    tick(3'd0, 1'b1);
  endtask

  task automatic test_rotate_move();
    press(3'd3);
    for (int i = 0; i < 3; i++) press(3'd1);
    checks++;
    if (bus.heading !== 2'd1 || bus.pos_x !== 4'd3 || bus.pos_y !== 4'd0) begin
      errors++;
      $display("FAIL rot_move got h=%0d pos=(%0d,%0d) want h=1 pos=(3,0)", bus.heading, bus.pos_x, bus.pos_y);
    end
    for (int i = 0; i < 12; i++) press(3'd1);
    tick(3'd1, 1'b1);
    checks++;
    if (bus.bump !== 1'b1 || bus.pos_x !== 4'd15) begin
      errors++;
      $display("FAIL east_border got bump=%0b x=%0d want bump=1 x=15", bus.bump, bus.pos_x);
    end
    tick(3'd0, 1'b1);
    checks++;
    if (bus.bump !== 1'b0) begin
      errors++;
      $display("FAIL bump_width got bump=%0b want 0", bus.bump);
    end
    for (int i = 0; i < 4; i++) press(3'd3);
    checks++;
    if (bus.heading !== 2'd1) begin
      errors++;
      $display("FAIL rot4 got h=%0d want 1", bus.heading);
    end
    press(3'd3);
    tick(3'd1, 1'b1);
    tick(3'd3, 1'b1);
    tick(3'd0, 1'b1);
    checks++;
    if (bus.heading !== 2'd2 || bus.pos_x !== 4'd15 || bus.pos_y !== 4'd1) begin
      errors++;
      $display("FAIL no_edge_change got h=%0d pos=(%0d,%0d) want h=2 pos=(15,1)", bus.heading, bus.pos_x, bus.pos_y);
    end
  endtask

  task automatic test_navigate();
    int k, ex, ey, eh;
    goto_35();
    tick(3'd4, 1'b1);
    checks++;
    if (bus.busy !== 1'b1 || bus.pos_x !== 4'd3 || bus.pos_y !== 4'd5 || bus.nav_done !== 1'b0) begin
      errors++;
      $display("FAIL nav_accept got busy=%0b pos=(%0d,%0d) done=%0b want busy=1 pos=(3,5) done=0",
               bus.busy, bus.pos_x, bus.pos_y, bus.nav_done);
    end
    for (int c = 1; c <= 32; c++) begin
      tick(3'd0, 1'b1);
      k  = c / 4;
      ex = (k <= 3) ? 3 - k : 0;
      ey = (k <= 3) ? 5 : 5 - (k - 3);
      eh = (k == 0) ? 2 : (k <= 3) ? 3 : 0;
      checks++;
      if (bus.pos_x !== 4'(ex) || bus.pos_y !== 4'(ey) || bus.heading !== 2'(eh) ||
          bus.busy !== (c < 32) || bus.nav_done !== (c == 32)) begin
        errors++;
        $display("FAIL nav_c%0d got pos=(%0d,%0d) h=%0d busy=%0b done=%0b want pos=(%0d,%0d) h=%0d busy=%0b done=%0b",
                 c, bus.pos_x, bus.pos_y, bus.heading, bus.busy, bus.nav_done, ex, ey, eh, (c < 32), (c == 32));
      end
    end
    tick(3'd0, 1'b1);
    checks++;
    if (bus.nav_done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL nav_after got done=%0b busy=%0b want 0 0", bus.nav_done, bus.busy);
    end
  endtask

  task automatic test_abort();
    goto_35();
    tick(3'd4, 1'b1);
    for (int c = 1; c <= 4; c++) tick(3'd0, 1'b1);
    tick(3'd2, 1'b1);
    checks++;
    if (bus.busy !== 1'b0 || bus.pos_x !== 4'd2 || bus.pos_y !== 4'd5 || bus.heading !== 2'd3 || bus.nav_done !== 1'b0) begin
      errors++;
      $display("FAIL abort got busy=%0b pos=(%0d,%0d) h=%0d done=%0b want busy=0 pos=(2,5) h=3 done=0",
               bus.busy, bus.pos_x, bus.pos_y, bus.heading, bus.nav_done);
    end
    for (int i = 0; i < 10; i++) begin
      tick(3'd0, 1'b1);
      checks++;
      if (bus.busy !== 1'b0 || bus.nav_done !== 1'b0 || bus.pos_x !== 4'd2 || bus.pos_y !== 4'd5) begin
        errors++;
        $display("FAIL abort_hold%0d got busy=%0b done=%0b pos=(%0d,%0d) want 0 0 (2,5)",
                 i, bus.busy, bus.nav_done, bus.pos_x, bus.pos_y);
      end
    end
    goto_35();
    tick(3'd4, 1'b1);
    for (int c = 1; c <= 3; c++) tick(3'd0, 1'b1);
    tick(3'd1, 1'b1);
    checks++;
    if (bus.busy !== 1'b0 || bus.pos_x !== 4'd3 || bus.pos_y !== 4'd5 || bus.heading !== 2'd2 ||
        bus.nav_done !== 1'b0 || bus.bump !== 1'b0) begin
      errors++;
      $display("FAIL abort_on_step got busy=%0b pos=(%0d,%0d) h=%0d done=%0b bump=%0b want 0 (3,5) 2 0 0",
               bus.busy, bus.pos_x, bus.pos_y, bus.heading, bus.nav_done, bus.bump);
    end
    tick(3'd0, 1'b1);
  endtask

  task automatic test_home_and_decode();
    tick(3'd0, 1'b0);
    tick(3'd0, 1'b1);
    tick(3'd4, 1'b1);
    checks++;
    if (bus.nav_done !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL nav_home got done=%0b busy=%0b want 1 0", bus.nav_done, bus.busy);
    end
    tick(3'd0, 1'b1);
    checks++;
    if (bus.nav_done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL nav_home_after got done=%0b busy=%0b want 0 0", bus.nav_done, bus.busy);
    end
    for (int i = 0; i < 5; i++) tick(3'd6, 1'b1);
    tick(3'd0, 1'b1);
    for (int i = 0; i < 3; i++) tick(3'd7, 1'b1);
    tick(3'd5, 1'b1);
    checks++;
    if (bus.pos_x !== 4'd0 || bus.pos_y !== 4'd0 || bus.heading !== 2'd0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL code_5to7 got pos=(%0d,%0d) h=%0d busy=%0b want (0,0) 0 0",
               bus.pos_x, bus.pos_y, bus.heading, bus.busy);
    end
    tick(3'd0, 1'b1);
  endtask

  task automatic test_reset_mid_nav();
    goto_35();
    tick(3'd4, 1'b1);
    for (int c = 1; c <= 8; c++) tick(3'd0, 1'b1);
    checks++;
    if (bus.pos_x !== 4'd1 || bus.pos_y !== 4'd5 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset got pos=(%0d,%0d) busy=%0b want (1,5) 1", bus.pos_x, bus.pos_y, bus.busy);
    end
    tick(3'd0, 1'b0);
    checks++;
    if ({bus.pos_x, bus.pos_y, bus.heading, bus.busy, bus.nav_done} !== 12'd0) begin
      errors++;
      $display("FAIL reset_mid_nav got pos=(%0d,%0d) h=%0d busy=%0b done=%0b want all 0",
               bus.pos_x, bus.pos_y, bus.heading, bus.busy, bus.nav_done);
    end
    for (int i = 0; i < 40; i++) begin
      tick(3'd0, 1'b1);
      checks++;
      if (bus.busy !== 1'b0 || bus.nav_done !== 1'b0 || bus.pos_x !== 4'd0 || bus.pos_y !== 4'd0) begin
        errors++;
        $display("FAIL post_reset%0d got busy=%0b done=%0b pos=(%0d,%0d) want 0 0 (0,0)",
                 i, bus.busy, bus.nav_done, bus.pos_x, bus.pos_y);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0] code;
    logic       rn;
    int         r, len;
    for (int n = 0; n < 500; n++) begin
      r = int'($urandom_range(0, 9));
      case (r)
        0, 1, 2, 3: code = 3'd0;
        4: code = 3'd1;
        5: code = 3'd2;
        6: code = 3'd3;
        7: code = 3'd4;
        default: code = 3'($urandom_range(5, 7));
      endcase
      len = (code == 3'd0) ? int'($urandom_range(1, 20)) : int'($urandom_range(1, 5));
      rn  = ($urandom_range(0, 79) != 0);
      for (int j = 0; j < len; j++) begin
        tick(code, (j == 0) ? rn : 1'b1);
        checks++;
        if ({bus.pos_x, bus.pos_y, bus.heading, bus.busy, bus.bump, bus.nav_done} !==
            {4'(m_x), 4'(m_y), 2'(m_h), m_busy, m_bump, m_done}) begin
          errors++;
          $display("FAIL random n%0d j%0d got pos=(%0d,%0d) h=%0d busy=%0b bump=%0b done=%0b want pos=(%0d,%0d) h=%0d busy=%0b bump=%0b done=%0b",
                   n, j, bus.pos_x, bus.pos_y, bus.heading, bus.busy, bus.bump, bus.nav_done,
                   m_x, m_y, m_h, m_busy, m_bump, m_done);
        end
      end
    end
  endtask

  initial begin
    bus.instruction = 3'd0;
    test_reset();
    test_border_hold();
    test_rotate_move();
    test_navigate();
    test_abort();
    test_home_and_decode();
    test_reset_mid_nav();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/f2_motion_ctrl.md
Name: f2_motion_ctrl

Overview:
- Downstream consumer of the function-2 key-processing stage's 3-bit instruction code (0 none, 1 forward, 2 backward, 3 rotate 90, 4 navigate).
- Keeps a cursor position and heading on a cell grid; the VGA drawing logic renders it.
- Executes one action per key press.
- Navigate walks the cursor back to the home cell, one cell per step interval, and can be aborted.

Parameters:
GRID_W, 16, grid width in cells (x range 0..GRID_W-1)
GRID_H, 12, grid height in cells (y range 0..GRID_H-1)
COORD_W, 4, width of pos_x/pos_y; must hold GRID_W-1 and GRID_H-1
HOME_X, 0, navigate target x and reset x
HOME_Y, 0, navigate target y and reset y
STEP_DIV, 25000000, sysclk cycles per navigate step (>=2)

Ports:
sysclk  in  1  system clock; all logic on posedge
rst_n  in  1  synchronous active-low reset
instruction  in  3  level code from the key-processing stage; held while the key is down
pos_x  out  COORD_W  cursor x cell
pos_y  out  COORD_W  cursor y cell (0 = top row, increases downward)
heading  out  2  0=N (y-1), 1=E (x+1), 2=S (y+1), 3=W (x-1)
busy  out  1  high while navigating
bump  out  1  one-cycle pulse: a move was blocked by the grid border
nav_done  out  1  one-cycle pulse: navigate reached home

Behaviour:
- One clock, sysclk. Reset is synchronous, active-low (rst_n sampled on posedge sysclk).
- Reset values:
  - pos_x=HOME_X, pos_y=HOME_Y, heading=0.
  - busy=0, bump=0, nav_done=0.
  - State IDLE, step counter 0, prev_cmd=0.
- Decode: codes 5..7 are treated as 0.
- Press edge: decoded cmd!=0 and prev_cmd==0.
  - prev_cmd is registered every cycle from the decoded cmd.
  - A held key acts once. A code change without passing through 0 (e.g. 1->3) is not an edge.
  - A nonzero code in the first cycle after reset release is an edge.
- Latency: an edge sampled at posedge N updates outputs at that same edge; new values are visible after edge N.
- bump and nav_done are high for exactly one cycle. Otherwise 0.
- State IDLE:
  - cmd 1: move one cell along heading.
  - cmd 2: move one cell opposite heading. Heading is unchanged.
  - Border: if the target cell is outside 0..GRID_W-1 / 0..GRID_H-1, position holds and bump=1.
  - cmd 3: heading <= heading+1 mod 4 (clockwise; 3->0).
  - cmd 4, pos == home: nav_done=1; stay IDLE; busy stays 0.
  - cmd 4, pos != home: go to NAV; busy=1; step counter=0.
- State NAV:
  - Step counter increments each cycle. At STEP_DIV-1 it returns to 0 and one step is taken.
  - First step occurs STEP_DIV cycles after NAV entry.
  - Step order: x first toward HOME_X, then y toward HOME_Y.
  - heading is set to the travel direction of each step (W/E for x, N/S for y).
  - When the step lands on home: nav_done=1, busy=0, next state IDLE, all on that same edge.
  - Edge of cmd 1/2/3: abort. On that edge busy=0, state IDLE, counter=0, position and heading frozen. The aborting command is not executed.
  - Edge of cmd 4: ignored.
- Reset mid-NAV: immediate return to reset values on the reset edge.
- Simultaneous events: an abort edge coinciding with a step edge means the abort wins; no step is taken and no nav_done pulse.
- NAV never produces bump, because steps always move toward home inside the grid.

Test Plan:
(bench overrides STEP_DIV=4; other params default)
- Reset: rst_n=0 for 2 cycles -> pos (0,0), heading 0, busy 0, bump 0, nav_done 0.
- Border + hold: after reset, hold instruction=1 for 10 cycles -> pos stays (0,0); bump high exactly 1 cycle, on the first edge; no further pulses.
- Rotate/move: press 3 once, then 1 three times (0 between presses) -> heading 1, pos (3,0). From x=15 facing E, press 1 -> pos x stays 15, bump pulse. Press 3 four times -> heading returns to the same value. Press 1 then 3 with no intervening 0 -> only forward executes.
- Navigate: from (3,5), press 4:
  - busy=1 on the accept edge.
  - Positions (2,5),(1,5),(0,5) then (0,4)..(0,0), one step every 4 cycles.
  - Heading 3 during x steps, 0 during y steps.
  - On the 8th step (32 cycles after accept): nav_done pulse and busy=0 on the same edge.
- Abort/edge cases:
  - From (3,5), press 4, then press 2 after the first step -> busy=0 on the abort edge; pos (2,5) frozen; no backward move; no nav_done.
  - Press 4 at home -> nav_done pulse on the accept edge; busy stays 0.
  - Code 6 held -> no action.
- Reset mid-NAV: rst_n=0 for 1 cycle during NAV at (1,5) -> pos (0,0), heading 0, busy 0; no nav_done.
